// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: PC -> imem request/ack -> IR valid/ready,
// then writes the next PC (sequential or redirected).
module fetch_ctrl #(
    parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic [31:0] PC_COUNT,
    output logic        PC_WRITE,
    output logic [31:0] PC_DIN,
    output logic        MEM_RDEN,
    output logic [31:0] MEM_ADDR,
    input  logic        MEM_ACK,
    input  logic [31:0] MEM_DOUT,
    input  logic        BR_TAKEN,
    input  logic [31:0] BR_TARGET,
    output logic        IR_VALID,
    input  logic        IR_READY,
    output logic [31:0] IR_DATA,
    output logic [31:0] IR_PC,
    output logic        MISALIGN
);

    typedef enum logic [1:0] {
        S_INIT,
        S_FETCH,
        S_HOLD
    } state_t;

    state_t      state_q, state_d;
    logic        pend_q, pend_d;
    logic [31:0] tgt_q, tgt_d;
    logic [31:0] ir_data_q, ir_data_d;
    logic [31:0] ir_pc_q, ir_pc_d;
    logic        mis_q, mis_d;

    logic [31:0] br_tgt;
    logic        br_mis;

    // Targets are word-aligned by dropping the low bits
    assign br_tgt = {BR_TARGET[31:2], 2'b00};
    assign br_mis = BR_TAKEN && (BR_TARGET[1:0] != 2'b00);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_INIT;
            pend_q    <= 1'b0;
            tgt_q     <= '0;
            ir_data_q <= '0;
            ir_pc_q   <= '0;
            mis_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            tgt_q     <= tgt_d;
            ir_data_q <= ir_data_d;
            ir_pc_q   <= ir_pc_d;
            mis_q     <= mis_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        tgt_d     = tgt_q;
        ir_data_d = ir_data_q;
        ir_pc_d   = ir_pc_q;
        mis_d     = mis_q;
        PC_WRITE  = 1'b0;
        PC_DIN    = '0;
        MEM_RDEN  = 1'b0;
        IR_VALID  = 1'b0;

        case (state_q)
            S_INIT: begin
                PC_WRITE = 1'b1;
                PC_DIN   = RESET_ADDR;
                state_d  = S_FETCH;
            end
            S_FETCH: begin
                MEM_RDEN = 1'b1;
                if (br_mis) mis_d = 1'b1;
                if (MEM_ACK && (pend_q || BR_TAKEN)) begin
                    PC_WRITE = 1'b1;
                    PC_DIN   = BR_TAKEN ? br_tgt : tgt_q;
                    pend_d   = 1'b0;
                end else if (MEM_ACK) begin
                    ir_data_d = MEM_DOUT;
                    ir_pc_d   = PC_COUNT;
                    state_d   = S_HOLD;
                end else if (BR_TAKEN) begin
                    pend_d = 1'b1;
                    tgt_d  = br_tgt;
                end
            end
            S_HOLD: begin
                IR_VALID = 1'b1;
                if (br_mis) mis_d = 1'b1;
                if (BR_TAKEN) begin
                    PC_WRITE = 1'b1;
                    PC_DIN   = br_tgt;
                    pend_d   = 1'b0;
                    state_d  = S_FETCH;
                end else if (IR_READY) begin
                    PC_WRITE = 1'b1;
                    PC_DIN   = pend_q ? tgt_q : ir_pc_q + 32'd4;
                    pend_d   = 1'b0;
                    state_d  = S_FETCH;
                end
            end
            default: state_d = S_INIT;
        endcase
    end

    assign MEM_ADDR = PC_COUNT;
    assign IR_DATA  = ir_data_q;
    assign IR_PC    = ir_pc_q;
    assign MISALIGN = mis_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random traffic
// checked every cycle against a transaction-level model.
module tb_fetch_ctrl;

    localparam logic [31:0] RA = 32'h0000_0100;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] PC_COUNT;
    logic        PC_WRITE;
    logic [31:0] PC_DIN;
    logic        MEM_RDEN;
    logic [31:0] MEM_ADDR;
    logic        MEM_ACK;
    logic [31:0] MEM_DOUT;
    logic        BR_TAKEN;
    logic [31:0] BR_TARGET;
    logic        IR_VALID;
    logic        IR_READY;
    logic [31:0] IR_DATA;
    logic [31:0] IR_PC;
    logic        MISALIGN;

    fetch_ctrl #(.RESET_ADDR(RA)) dut (
        .CLK(CLK), .RST_N(RST_N), .PC_COUNT(PC_COUNT),
        .PC_WRITE(PC_WRITE), .PC_DIN(PC_DIN),
        .MEM_RDEN(MEM_RDEN), .MEM_ADDR(MEM_ADDR),
        .MEM_ACK(MEM_ACK), .MEM_DOUT(MEM_DOUT),
        .BR_TAKEN(BR_TAKEN), .BR_TARGET(BR_TARGET),
        .IR_VALID(IR_VALID), .IR_READY(IR_READY),
        .IR_DATA(IR_DATA), .IR_PC(IR_PC), .MISALIGN(MISALIGN)
    );

    always #5 CLK = ~CLK;

    // External PC register
    logic [31:0] pc_reg = 32'h0;
    always @(posedge CLK) if (PC_WRITE) pc_reg <= PC_DIN;
    assign PC_COUNT = pc_reg;

    int checks = 0;
    int errors = 0;

    // Memory behaviour: 0 random ack, 1 fixed latency, 2 always ack
    int ack_mode = 2;
    int lat = 1;
    int wcnt = 0;

    // Model: a word either is awaited from memory or sits in IR
    bit          m_boot;
    bit          m_have;
    logic [31:0] m_pc;
    bit          m_redir;
    logic [31:0] m_redir_to;
    logic [31:0] m_word;
    logic [31:0] m_addr;
    bit          m_mis;

    // Last-cycle observations for literal checks
    logic        o_pcw, o_rden, o_valid, o_mis;
    logic [31:0] o_pcdin, o_irpc;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_boot = 1; m_have = 0; m_pc = '0;
        m_redir = 0; m_redir_to = '0;
        m_word = '0; m_addr = '0; m_mis = 0;
        wcnt = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".pcw"}, {31'b0, PC_WRITE}, 32'd1);
        chk({tag, ".pcdin"}, PC_DIN, 32'h0000_0100);
        chk({tag, ".rden"}, {31'b0, MEM_RDEN}, 32'd0);
        chk({tag, ".valid"}, {31'b0, IR_VALID}, 32'd0);
        chk({tag, ".irdata"}, IR_DATA, 32'd0);
        chk({tag, ".irpc"}, IR_PC, 32'd0);
        chk({tag, ".mis"}, {31'b0, MISALIGN}, 32'd0);
    endtask

    // Async reset applied mid-cycle, released just after a rising edge
    task automatic do_reset();
        @(negedge CLK);
        #2 RST_N = 1'b0;
        #1 chk_reset_outputs("rst");
        model_reset();
        @(posedge CLK);
        @(posedge CLK);
        #2 RST_N = 1'b1;
    endtask

    task automatic cyc(input bit br, input logic [31:0] brt, input bit rdy);
        logic [31:0] al;
        bit          e_pcw, e_rden, e_valid, fix;
        logic [31:0] e_pcdin;
        @(negedge CLK);
        BR_TAKEN  = br;
        BR_TARGET = brt;
        IR_READY  = rdy;
        MEM_DOUT  = $urandom;
        case (ack_mode)
            0: MEM_ACK = ($urandom % 2) == 0;
            1: MEM_ACK = MEM_RDEN && (wcnt == lat - 1);
            default: MEM_ACK = 1'b1;
        endcase
        #1;
        al  = brt & ~32'd3;
        fix = brt[1:0] != 2'b00;
        e_pcw = 0; e_pcdin = '0; e_rden = 0; e_valid = 0;
        if (m_boot) begin
            e_pcw = 1; e_pcdin = RA;
        end else if (!m_have) begin
            e_rden = 1;
            if (MEM_ACK && (br || m_redir)) begin
                e_pcw = 1; e_pcdin = br ? al : m_redir_to;
            end
        end else begin
            e_valid = 1;
            if (br) begin
                e_pcw = 1; e_pcdin = al;
            end else if (rdy) begin
                e_pcw = 1; e_pcdin = m_redir ? m_redir_to : m_addr + 32'd4;
            end
        end
        chk("pc_write", {31'b0, PC_WRITE}, {31'b0, e_pcw});
        if (e_pcw) chk("pc_din", PC_DIN, e_pcdin);
        chk("mem_rden", {31'b0, MEM_RDEN}, {31'b0, e_rden});
        if (e_rden) chk("mem_addr", MEM_ADDR, m_pc);
        chk("ir_valid", {31'b0, IR_VALID}, {31'b0, e_valid});
        chk("ir_data", IR_DATA, m_word);
        chk("ir_pc", IR_PC, m_addr);
        chk("misalign", {31'b0, MISALIGN}, {31'b0, m_mis});
        o_pcw = PC_WRITE; o_pcdin = PC_DIN; o_rden = MEM_RDEN;
        o_valid = IR_VALID; o_irpc = IR_PC; o_mis = MISALIGN;

        if (!m_boot && br && fix) m_mis = 1;
        if (m_boot) begin
            m_boot = 0;
        end else if (!m_have) begin
            if (MEM_ACK && (br || m_redir)) m_redir = 0;
            else if (MEM_ACK) begin
                m_word = MEM_DOUT; m_addr = m_pc; m_have = 1;
            end else if (br) begin
                m_redir = 1; m_redir_to = al;
            end
        end else if (br || rdy) begin
            m_have = 0; m_redir = 0;
        end
        if (e_pcw) m_pc = e_pcdin;

        if (MEM_RDEN && !MEM_ACK) wcnt++;
        else wcnt = 0;
    endtask

    initial begin
        int nv, nr, np;
        logic [31:0] vq[$];
        RST_N = 1'b0; MEM_ACK = 0; MEM_DOUT = '0;
        BR_TAKEN = 0; BR_TARGET = '0; IR_READY = 0;
        #1 chk_reset_outputs("por");
        model_reset();
        @(posedge CLK);
        #2 RST_N = 1'b1;

        // Zero-wait memory, decode always ready
        ack_mode = 2;
        nv = 0;
        for (int i = 0; i < 7; i++) begin
            cyc(0, '0, 1);
            if (i == 0) chk("init_pcdin", o_pcdin, 32'h100);
            if (o_valid) vq.push_back(o_irpc);
        end
        chk("seq_count", vq.size(), 32'd3);
        if (vq.size() == 3) begin
            chk("seq0", vq[0], 32'h100);
            chk("seq1", vq[1], 32'h104);
            chk("seq2", vq[2], 32'h108);
        end

        // Three-cycle memory latency, decode stalled
        ack_mode = 1; lat = 3;
        nr = 0; nv = 0;
        for (int i = 0; i < 20 && nv == 0; i++) begin
            cyc(0, '0, 0);
            if (o_rden) nr++;
            if (o_valid) nv = 1;
        end
        chk("lat3_valid_seen", nv, 32'd1);
        chk("lat3_rden_cycles", nr, 32'd3);

        // Stall five cycles in HOLD, then release
        np = 0;
        for (int i = 0; i < 5; i++) begin
            cyc(0, '0, 0);
            if (o_pcw || o_rden) np++;
        end
        chk("stall_quiet", np, 32'd0);
        cyc(0, '0, 1);
        chk("release_pcdin", o_pcdin, 32'h110);

        // Two redirects during a fetch wait: latest wins
        cyc(1, 32'h400, 0);
        cyc(1, 32'h500, 0);
        cyc(0, '0, 0);
        chk("redir_pcw", {31'b0, o_pcw}, 32'd1);
        chk("redir_pcdin", o_pcdin, 32'h500);
        chk("redir_discard", {31'b0, o_valid}, 32'd0);
        nv = 0;
        for (int i = 0; i < 20 && nv == 0; i++) begin
            cyc(0, '0, 0);
            if (o_valid) nv = 1;
        end
        chk("redir_irpc", o_irpc, 32'h500);

        // Misaligned redirect in HOLD, then wrap of PC+4
        cyc(1, 32'h203, 0);
        chk("mis_pcdin", o_pcdin, 32'h200);
        ack_mode = 2;
        cyc(1, 32'hFFFF_FFFC, 0);
        chk("mis_set", {31'b0, o_mis}, 32'd1);
        chk("top_pcdin", o_pcdin, 32'hFFFF_FFFC);
        cyc(0, '0, 0);
        cyc(0, '0, 1);
        chk("wrap_irpc", o_irpc, 32'hFFFF_FFFC);
        chk("wrap_pcdin", o_pcdin, 32'h0);
        chk("mis_sticky", {31'b0, o_mis}, 32'd1);

        // Reset during a fetch wait; stale ack in INIT
        ack_mode = 1; lat = 5;
        cyc(0, '0, 0);
        cyc(0, '0, 0);
        ack_mode = 2;
        do_reset();
        cyc(0, '0, 1);
        chk("rr_init_valid", {31'b0, o_valid}, 32'd0);
        chk("rr_init_pcdin", o_pcdin, 32'h100);
        cyc(0, '0, 1);
        chk("rr_fetch_valid", {31'b0, o_valid}, 32'd0);
        cyc(0, '0, 1);
        chk("rr_hold_valid", {31'b0, o_valid}, 32'd1);
        chk("rr_hold_irpc", o_irpc, 32'h100);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] t;
            bit b;
            if (i % 700 == 350) do_reset();
            if (i % 250 == 0) begin
                ack_mode = $urandom_range(0, 2);
                lat = $urandom_range(1, 4);
            end
            b = ($urandom % 6) == 0;
            t = $urandom;
            if (($urandom % 4) != 0) t = t & ~32'd3;
            cyc(b, t, ($urandom % 3) != 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
